// File: rtl/mult_share_pkg.sv
// Shared widths, helpers and types for the shared fixed-point multiplier slice.
package mult_share_pkg;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_A_WIDTH   = 16;
  localparam int DEFAULT_B_WIDTH   = 16;
  localparam int DEFAULT_OUT_SCALE = 16;

  // Tag width that never collapses to zero bits, even for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [clog2_min1(DEFAULT_N_REQ)-1:0] req_id_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/fxp_mult.sv
// Signed fixed-point multiplier: full product, arithmetic right shift, low bits kept.
module fxp_mult #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_SCALE = 16
) (
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  output logic [OUT_WIDTH-1:0] p_o
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0] aExt;
  logic signed [PW-1:0] bExt;
  logic signed [PW-1:0] full;
  logic signed [PW-1:0] shifted;

  assign aExt    = PW'($signed(a_i));
  assign bExt    = PW'($signed(b_i));
  assign full    = aExt * bExt;
  assign shifted = full >>> OUT_SCALE;
  assign p_o     = OUT_WIDTH'(shifted);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] hiMask;
  logic [N-1:0] cand;

  // Prefer requests at or above the pointer; fall back to the full vector to wrap.
  always_comb begin
    hiMask  = ~((N'(1) << ptr_i) - N'(1));
    cand    = (|(req_i & hiMask)) ? (req_i & hiMask) : req_i;
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
    if (!en_i) begin
      grant_o = '0;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one fixed-point multiplier among N_REQ requesters via round-robin grants
// into a single registered, ID-tagged result slot with downstream backpressure.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int ID_WIDTH  = clog2_min1(N_REQ),
  parameter int A_WIDTH   = DEFAULT_A_WIDTH,
  parameter int B_WIDTH   = DEFAULT_B_WIDTH,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int OUT_SCALE = DEFAULT_OUT_SCALE
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_WIDTH-1:0] req_a,
  input  logic [N_REQ*B_WIDTH-1:0] req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic [15:0]              grant_count
);

  slot_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [OUT_WIDTH-1:0] outData_q;
  logic [ID_WIDTH-1:0]  outId_q;
  logic [15:0]          grantCnt_q;

  logic                 slotFree;
  logic                 arbEn;
  logic                 fire;
  logic [N_REQ-1:0]     grant;
  logic [ID_WIDTH-1:0]  grantId;
  logic [A_WIDTH-1:0]   selA;
  logic [B_WIDTH-1:0]   selB;
  logic [OUT_WIDTH-1:0] product;

  // Grants are suppressed while reset is held so nothing handshakes into a cleared slot.
  assign slotFree  = (state_q == SLOT_EMPTY) || out_ready;
  assign arbEn     = slotFree && arst_n_in;
  assign req_ready = grant;
  assign fire      = |(req_valid & grant);

  rr_arbiter #(
    .N  (N_REQ),
    .PW (ID_WIDTH)
  ) uArb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arbEn),
    .grant_o (grant)
  );

  always_comb begin
    grantId = '0;
    selA    = '0;
    selB    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grantId = ID_WIDTH'(i);
        selA    = req_a[i*A_WIDTH +: A_WIDTH];
        selB    = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  fxp_mult #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SCALE (OUT_SCALE)
  ) uMul (
    .a_i (selA),
    .b_i (selB),
    .p_o (product)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= '0;
      outData_q  <= '0;
      outId_q    <= '0;
      grantCnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (fire) begin
        outData_q  <= product;
        outId_q    <= grantId;
        grantCnt_q <= grantCnt_q + 16'd1;
      end
    end
  end

  // A refill on the same edge as a drain keeps the slot full.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (fire) begin
      state_d = SLOT_FULL;
      ptr_d   = (grantId == ID_WIDTH'(N_REQ - 1)) ? '0 : grantId + ID_WIDTH'(1);
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    out_valid   = (state_q == SLOT_FULL);
    out_data    = outData_q;
    out_id      = outId_q;
    grant_count = grantCnt_q;
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed plan items followed by
// randomized traffic compared against a behavioural round-robin/slot model.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_id;
  logic [15:0]   grant_count;

  logic [15:0] opA [N];
  logic [15:0] opB [N];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          mValid;
  logic [31:0] mData;
  int          mId;
  logic [15:0] mCnt;
  int          mPtr;

  always #5 clk = ~clk;

  mult_share_arbiter dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .grant_count (grant_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Floor of (a*b)/2^16, truncated to 32 bits.
  function automatic logic [31:0] refScale(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p / 65536;
    if ((p % 65536) != 0 && p < 0) q = q - 1;
    return q[31:0];
  endfunction

  function automatic int modelGrant(input logic [N-1:0] v, input bit rdy);
    int idx;
    if (mValid && !rdy) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (mPtr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] randOp();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mData  = '0;
    mId    = 0;
    mCnt   = '0;
    mPtr   = 0;
  endtask

  // One clock of stimulus: checks the combinational grant, then the registered slot.
  task automatic applyStimulus(input logic [N-1:0] v, input bit rdy, output int g);
    req_valid = v;
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = opA[i];
      req_b[i*16 +: 16] = opB[i];
    end
    #1;
    g = modelGrant(v, rdy);
    checkOutput("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    @(posedge clk);
    if (g >= 0) begin
      mValid = 1'b1;
      mId    = g;
      mData  = refScale(opA[g], opB[g]);
      mCnt   = mCnt + 16'd1;
      mPtr   = (g + 1) % N;
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput("out_valid", 64'(out_valid), 64'(mValid));
    checkOutput("out_data", 64'(out_data), 64'(mData));
    checkOutput("out_id", 64'(out_id), 64'(mId));
    checkOutput("grant_count", 64'(grant_count), 64'(mCnt));
  endtask

  initial begin
    int g;
    logic [31:0] holdExp;
    logic [N-1:0] pend;
    bit rdy;

    arst_n_in = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      opA[i] = 16'(i + 1);
      opB[i] = 16'(i + 5);
    end
    modelReset();

    #12;
    checkOutput("rst_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_data", 64'(out_data), 64'(0));
    checkOutput("rst_id", 64'(out_id), 64'(0));
    checkOutput("rst_count", 64'(grant_count), 64'(0));
    checkOutput("rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 arst_n_in = 1'b1;

    // Plan 1: basic positive product
    opA[0] = 16'h0100; opB[0] = 16'h0200;
    applyStimulus(4'b0001, 1'b1, g);
    checkOutput("tp1_data", 64'(out_data), 64'(32'd2));

    // Plan 2: signed and floor behaviour
    opA[0] = 16'hFF00; opB[0] = 16'h0200;
    applyStimulus(4'b0001, 1'b1, g);
    checkOutput("tp2_neg", 64'(out_data), 64'(32'hFFFF_FFFE));
    opA[0] = 16'hFFFF; opB[0] = 16'h0001;
    applyStimulus(4'b0001, 1'b1, g);
    checkOutput("tp2_floor", 64'(out_data), 64'(32'hFFFF_FFFF));

    // Grant requester 3 so the pointer wraps back to 0
    opA[3] = 16'h1234; opB[3] = 16'h0100;
    applyStimulus(4'b1000, 1'b1, g);

    // Plan 3: all requesting, sustained throughput
    for (int i = 0; i < N; i++) begin
      opA[i] = 16'(16'h0300 * (i + 1));
      opB[i] = 16'(16'hF000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b1, g);
      checkOutput("tp3_id", 64'(out_id), 64'(i % 4));
      checkOutput("tp3_valid", 64'(out_valid), 64'(1));
    end

    // Plan 4: stall then release
    holdExp = refScale(opA[3], opB[3]);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1010, 1'b0, g);
      checkOutput("tp4_hold", 64'(out_data), 64'(holdExp));
    end
    applyStimulus(4'b1010, 1'b1, g);
    checkOutput("tp4_id", 64'(out_id), 64'(1));
    checkOutput("tp4_valid", 64'(out_valid), 64'(1));

    // Plan 5: pointer at 2 wraps to index 0, then index 1
    applyStimulus(4'b0011, 1'b1, g);
    checkOutput("tp5_wrap", 64'(out_id), 64'(0));
    applyStimulus(4'b0011, 1'b1, g);
    checkOutput("tp5_next", 64'(out_id), 64'(1));

    // Plan 6: asynchronous reset mid-stream
    applyStimulus(4'b1111, 1'b1, g);
    #2 arst_n_in = 1'b0;
    #1;
    checkOutput("tp6_valid", 64'(out_valid), 64'(0));
    checkOutput("tp6_count", 64'(grant_count), 64'(0));
    checkOutput("tp6_ready", 64'(req_ready), 64'(0));
    modelReset();
    @(posedge clk);
    #1 arst_n_in = 1'b1;
    applyStimulus(4'b1111, 1'b1, g);
    checkOutput("tp6_first", 64'(out_id), 64'(0));

    // Randomized traffic honouring the hold-until-granted protocol
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          opA[i]  = randOp();
          opB[i]  = randOp();
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(pend, rdy, g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
